// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared widths, scan states and 7-segment glyph constants
package seg_pkg;

    localparam int SEG_W       = 8;
    localparam int DIGIT_IDX_W = 3;

    typedef enum logic [1:0] {
        GUARD = 2'd0,
        LIT   = 2'd1,
        DARK  = 2'd2
    } scan_state_t;

    // bit7 = dp, bits6..0 = g..a
    localparam logic [SEG_W-1:0] GLYPH_0     = 8'b0011_1111;
    localparam logic [SEG_W-1:0] GLYPH_1     = 8'b0000_0110;
    localparam logic [SEG_W-1:0] GLYPH_2     = 8'b0101_1011;
    localparam logic [SEG_W-1:0] GLYPH_3     = 8'b0100_1111;
    localparam logic [SEG_W-1:0] GLYPH_4     = 8'b0110_0110;
    localparam logic [SEG_W-1:0] GLYPH_5     = 8'b0110_1101;
    localparam logic [SEG_W-1:0] GLYPH_6     = 8'b0111_1101;
    localparam logic [SEG_W-1:0] GLYPH_7     = 8'b0000_0111;
    localparam logic [SEG_W-1:0] GLYPH_8     = 8'b0111_1111;
    localparam logic [SEG_W-1:0] GLYPH_9     = 8'b0110_1111;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 8'b0000_0000;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - resettable divider producing a 1-cycle tick every TICK_DIV clocks
module scan_prescaler #(
    parameter int TICK_DIV = 3375
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 7-segment scan scheduler with double-buffered glyphs, blank guard and PWM; SEG_LAMP_TEST_EN adds lamp_test
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 3375,
    parameter int BRIGHT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SEG_LAMP_TEST_EN
    input  logic                   lamp_test,
`endif
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DIGIT_IDX_W-1:0] wr_addr,
    input  logic [SEG_W-1:0]       wr_data,
    input  logic                   commit,
    input  logic [BRIGHT_W-1:0]    brightness,
    output logic [SEG_W-1:0]       seg_out,
    output logic [NUM_DIGITS-1:0]  dig_sel,
    output logic                   frame_done
);

    localparam logic [DIGIT_IDX_W-1:0] LAST_IDX = DIGIT_IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIGIT_IDX_W:0]   NUM_D    = (DIGIT_IDX_W + 1)'(NUM_DIGITS);

    logic                   tick;
    logic                   lamp_in;
    logic                   lamp_q;
    logic [BRIGHT_W-1:0]    sub;
    logic [BRIGHT_W-1:0]    sub_nx;
    logic [BRIGHT_W-1:0]    bright_eff;
    logic [DIGIT_IDX_W-1:0] idx;
    scan_state_t            state;
    scan_state_t            state_nx;
    logic                   last_sub;
    logic                   boundary;
    logic                   boundary_q;
    logic                   swap;
    logic                   wr_fire;
    logic                   commit_pending;
    logic [SEG_W-1:0]       back    [NUM_DIGITS];
    logic [SEG_W-1:0]       back_nx [NUM_DIGITS];
    logic [SEG_W-1:0]       front   [NUM_DIGITS];

`ifdef SEG_LAMP_TEST_EN
    assign lamp_in = lamp_test;
`else
    assign lamp_in = 1'b0;
`endif

    scan_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wr_ready   = !commit_pending;
    assign wr_fire    = wr_valid && wr_ready && ({1'b0, wr_addr} < NUM_D);
    assign last_sub   = (sub == '1);
    assign boundary   = tick && last_sub && (idx == LAST_IDX);
    // A commit arriving on the boundary tick itself still makes this swap
    assign swap       = boundary && (commit_pending || commit);
    assign bright_eff = lamp_in ? '1 : brightness;

    always_comb begin
        sub_nx   = sub + 1'b1;
        state_nx = state;
        if (tick) begin
            if (sub_nx == '0) begin
                state_nx = GUARD;
            end else if (sub_nx <= bright_eff) begin
                state_nx = LIT;
            end else begin
                state_nx = DARK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GUARD;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub            <= '0;
            idx            <= '0;
            lamp_q         <= 1'b0;
            boundary_q     <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            boundary_q <= boundary;
            if (tick) begin
                sub    <= sub_nx;
                lamp_q <= lamp_in;
                if (last_sub) begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
            end
            if (swap) begin
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Same-cycle write is folded in before the copy so it lands in the new frame
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            back_nx[i] = back[i];
        end
        if (wr_fire) begin
            back_nx[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                back[i]  <= GLYPH_BLANK;
                front[i] <= GLYPH_BLANK;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                back[i] <= back_nx[i];
                if (swap) begin
                    front[i] <= back_nx[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= '0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary_q;
            if (state == LIT) begin
                seg_out <= lamp_q ? {SEG_W{1'b1}} : front[idx];
                dig_sel <= NUM_DIGITS'(1) << idx;
            end else begin
                seg_out <= '0;
                dig_sel <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized bench for seg_scan_ctrl against a cycle-count reference model
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int TD    = 4;
    localparam int BW    = 3;
    localparam int ND    = 6;
    localparam int SUBS  = 1 << BW;
    localparam int FRAME = TD * SUBS * ND;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          commit = 1'b0;
    logic [BW-1:0] brightness = '1;
    logic [7:0]    seg_out;
    logic [ND-1:0] dig_sel;
    logic          frame_done;
    logic          lamp_m;
`ifdef SEG_LAMP_TEST_EN
    logic          lamp_test = 1'b0;
    assign lamp_m = lamp_test;
`else
    assign lamp_m = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .BRIGHT_W   (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SEG_LAMP_TEST_EN
        .lamp_test  (lamp_test),
`endif
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .brightness (brightness),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position on screen derived from the count of elapsed subticks
    int         m_c, m_st, m_sub, m_idx, m_bq;
    bit         m_pend, m_lq, m_flag;
    logic [7:0] m_back [ND];
    logic [7:0] m_front[ND];
    logic [7:0] e_seg;
    logic [ND-1:0] e_dig;
    logic       e_fd;

    always @(posedge clk) begin
        if (rst) begin
            m_c = 0; m_st = 0; m_bq = 0; m_pend = 0; m_lq = 0; m_flag = 0;
            e_seg = '0; e_dig = '0; e_fd = 0;
            for (int i = 0; i < ND; i++) begin
                m_back[i] = '0;
                m_front[i] = '0;
            end
        end else begin
            m_sub = m_st % SUBS;
            m_idx = (m_st / SUBS) % ND;
            if (m_sub != 0 && m_sub <= m_bq) begin
                e_dig = ND'(1 << m_idx);
                e_seg = m_lq ? 8'hFF : m_front[m_idx];
            end else begin
                e_dig = '0;
                e_seg = '0;
            end
            e_fd = m_flag;
            m_flag = 0;
            if (wr_valid && !m_pend && wr_addr < ND) m_back[wr_addr] = wr_data;
            if (commit) m_pend = 1;
            if (m_c % TD == TD - 1) begin
                m_st++;
                m_bq = lamp_m ? SUBS - 1 : int'(brightness);
                m_lq = lamp_m;
                if (m_st % (SUBS * ND) == 0) begin
                    m_flag = 1;
                    if (m_pend) begin
                        m_front = m_back;
                        m_pend = 0;
                    end
                end
            end
            m_c++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("seg_out", 32'(seg_out), 32'(e_seg));
            check("dig_sel", 32'(dig_sel), 32'(e_dig));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            check("wr_ready", 32'(wr_ready), 32'(!m_pend));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int k = 0;
        while (frame_done !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        if (frame_done !== 1'b1) check({tag, "_timeout"}, 32'(k), 32'(2 * FRAME - 1));
    endtask

    task automatic wait_dig(input int d, input string tag);
        int k = 0;
        while (dig_sel !== ND'(1 << d) && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        if (dig_sel !== ND'(1 << d)) check({tag, "_timeout"}, 32'(k), 32'(2 * FRAME - 1));
    endtask

    task automatic count_frame(output int lit, output int fds, output bit seg_ok);
        lit = 0; fds = 0; seg_ok = 1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (dig_sel != '0) lit++;
            if (dig_sel == '0 && seg_out != '0) seg_ok = 0;
            if (frame_done) fds++;
        end
    endtask

    logic [7:0] glyphs[10];
    logic [7:0] disp[ND];
    int lit, fds, k;
    bit seg_ok;

    initial begin
        glyphs = '{GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4,
                   GLYPH_5, GLYPH_6, GLYPH_7, GLYPH_8, GLYPH_9};
        brightness = 3'd7;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg_out), 32'h0);
        check("rst_dig", 32'(dig_sel), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        chk_en = 1;
        rst = 1'b0;
        k = 0;
        while (dig_sel == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("first_lit_lat", 32'(k), 32'd5);
        check("first_lit_dig", 32'(dig_sel), 32'h1);

        for (int i = 0; i < ND; i++) begin
            wr(3'(i), glyphs[i + 1]);
            disp[i] = glyphs[i + 1];
        end
        pulse_commit();
        check("ready_pending", 32'(wr_ready), 32'h0);
        wait_fd("fd_commit");
        @(negedge clk);
        check("ready_after_swap", 32'(wr_ready), 32'h1);
        for (int d = 0; d < ND; d++) begin
            wait_dig(d, "show");
            check($sformatf("show_dig%0d", d), 32'(seg_out), 32'(disp[d]));
        end
        count_frame(lit, fds, seg_ok);
        check("fd_per_frame", 32'(fds), 32'd1);
        count_frame(lit, fds, seg_ok);
        check("fd_per_frame2", 32'(fds), 32'd1);

        brightness = 3'd3;
        wait_fd("fd_b3");
        count_frame(lit, fds, seg_ok);
        check("lit_b3", 32'(lit), 32'(ND * 3 * TD));
        brightness = 3'd0;
        wait_fd("fd_b0");
        count_frame(lit, fds, seg_ok);
        check("lit_b0", 32'(lit), 32'd0);
        brightness = 3'd7;

        check("ready_addr7", 32'(wr_ready), 32'h1);
        wr(3'd7, 8'hAA);
        wr(3'd4, GLYPH_0);
        wait_fd("fd_nocommit");
        wait_dig(4, "nocommit");
        check("nocommit_dig4", 32'(seg_out), 32'(disp[4]));
        pulse_commit();
        disp[4] = GLYPH_0;
        wait_fd("fd_a7");
        for (int d = 0; d < ND; d++) begin
            wait_dig(d, "a7");
            check($sformatf("a7_dig%0d", d), 32'(seg_out), 32'(disp[d]));
        end

        wait_fd("fd_align");
        wr(3'd0, GLYPH_8);
        repeat (FRAME - 4) @(negedge clk);
        pulse_commit();
        disp[0] = GLYPH_8;
        wait_fd("fd_bcommit");
        wait_dig(0, "bcommit");
        check("bcommit_dig0", 32'(seg_out), 32'(GLYPH_8));

        wr_valid = 1'b1; wr_addr = 3'd2; wr_data = GLYPH_9; commit = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; commit = 1'b0;
        disp[2] = GLYPH_9;
        wait_fd("fd_wc");
        wait_dig(2, "wc");
        check("wc_dig2", 32'(seg_out), 32'(GLYPH_9));

        wait_dig(3, "mid");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_seg", 32'(seg_out), 32'h0);
        check("midrst_dig", 32'(dig_sel), 32'h0);
        rst = 1'b0;
        wait_dig(0, "midrst_restart");
        check("midrst_cleared", 32'(seg_out), 32'h0);

`ifdef SEG_LAMP_TEST_EN
        lamp_test = 1'b1;
        brightness = 3'd1;
        wait_fd("fd_lamp");
        count_frame(lit, fds, seg_ok);
        check("lamp_lit", 32'(lit), 32'(ND * (SUBS - 1) * TD));
        wait_dig(1, "lamp");
        check("lamp_seg", 32'(seg_out), 32'hFF);
        lamp_test = 1'b0;
        brightness = 3'd7;
`endif

        for (int i = 0; i < 4000; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            commit = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 149) == 0) brightness = BW'($urandom);
`ifdef SEG_LAMP_TEST_EN
            if ($urandom_range(0, 299) == 0) lamp_test = ~lamp_test;
`endif
            rst = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        wr_valid = 1'b0; commit = 1'b0; rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 6-digit multiplexed 7-segment display. It owns a double-buffered 6-entry glyph store and a write handshake for producers. It time-shares the single segment bus between digits with an anti-ghosting blank guard and PWM brightness. It replaces the free-running timer-plus-mux arrangement in the top level, and the top level applies any board polarity inversion.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (1..8)
TICK_DIV, 3375, clk cycles per scan subtick (125 us at 27 MHz)
BRIGHT_W, 3, brightness width; each digit slot is 2**BRIGHT_W subticks

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
wr_valid  in  1  producer write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  3  digit index, 0 = rightmost
wr_data  in  8  glyph, bit7 = dp, bits6..0 = g..a
commit  in  1  pulse: publish the back buffer at the next frame boundary
brightness  in  BRIGHT_W  lit subticks per slot, 0 = dark
seg_out  out  8  segment drive, active-high
dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high
frame_done  out  1  1-cycle pulse after the last digit slot of each frame

Behaviour:
- One clock clk; reset rst is synchronous and active-high.
- Reset clears both buffers to 0, prescaler, subtick, digit index, commit_pending, seg_out, dig_sel and frame_done to 0. wr_ready is 1 after reset.
- Prescaler counts 0..TICK_DIV-1. tick is high for 1 cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Subtick counter sub (BRIGHT_W bits) advances on tick.
- When sub wraps from all-ones to 0, the digit index advances. Index wraps NUM_DIGITS-1 -> 0; that wrap is the frame boundary.
- FSM per slot:
  - GUARD: active when sub == 0. dig_sel = 0 and seg_out = 0, which is the anti-ghosting blank.
  - LIT: active when 1 <= sub <= brightness. dig_sel has the bit for the index set; seg_out = front[index].
  - DARK: active when sub > brightness. Outputs are 0.
- brightness is sampled each subtick; a change mid-slot takes effect at the next tick. brightness = 2**BRIGHT_W-1 gives a maximum duty of 7/8.
- seg_out and dig_sel are registered: they change 1 cycle after the tick that changes the state.
- Writes:
  - Accepted writes update back[wr_addr] on the next clock.
  - wr_addr >= NUM_DIGITS is accepted and dropped.
- Commit:
  - commit sets commit_pending, and wr_ready = !commit_pending.
  - At the frame boundary tick, if commit_pending is set: front <= back (whole copy, same cycle) and commit_pending is cleared. wr_ready returns to 1 on the following cycle.
  - commit while already pending has no extra effect.
  - commit in the same cycle as the boundary tick is taken at that boundary.
  - A write in the same cycle as commit is accepted: wr_ready is still 1 in that cycle, and the write is included in the copy.
- frame_done pulses for 1 cycle, coincident with the registered output update of the frame boundary, and whether or not a swap occurred.
- rst mid-frame blanks the outputs on the next cycle, discards the buffers and the pending commit, and restarts at digit 0 with sub 0.

Optional Feature:
SEG_LAMP_TEST_EN:
- Defined: adds input lamp_test (1 bit). While it is high, LIT emits seg_out = 8'hFF, and brightness is treated as all-ones. GUARD still blanks. Buffers are untouched.
- Undefined: no lamp_test port; behaviour as above.

Decomposition:
- Package seg_pkg:
  - SEG_W = 8
  - DIGIT_IDX_W = 3
  - enum scan_state_t {GUARD, LIT, DARK}
  - glyph constants GLYPH_0..GLYPH_9 (e.g. GLYPH_1 = 8'b00000110, GLYPH_8 = 8'b01111111), GLYPH_BLANK = 0
- Sub-module scan_prescaler (parameter TICK_DIV; ports clk, rst, tick): a resettable successor of the existing timer, reusable by other blocks.

Test Plan:
- Test parameters: TICK_DIV = 4, BRIGHT_W = 3.
- Reset: assert rst for 3 cycles -> seg_out = 0, dig_sel = 0, wr_ready = 1, frame_done = 0; the first lit output is digit 0 after 1 guard subtick (4 cycles + 1 register cycle).
- Write and commit: write GLYPH_1..GLYPH_6 to addr 0..5, then pulse commit -> wr_ready = 0 until the frame boundary. The next frame shows dig_sel = 6'b000001 with seg_out = 8'h06 ... dig_sel = 6'b100000 with seg_out = 8'h7D. frame_done pulses exactly once per 6*8*4 = 192 cycles.
- Brightness:
  - brightness = 3 -> each slot is 1 guard subtick, then 3 lit subticks (12 cycles), then 4 dark subticks.
  - brightness = 0 -> dig_sel stays 0 for a whole frame.
- Edge cases:
  - Write to addr 7 -> accepted, and no buffer entry changes after commit.
  - Write without commit -> the displayed content is unchanged.
- Simultaneous events:
  - commit on the boundary-tick cycle -> swap at that boundary.
  - Write plus commit in the same cycle -> the write is visible in the new frame.
- Mid-frame reset: rst during digit 3 LIT -> outputs are 0 the next cycle, the restart is at digit 0, and the committed content is cleared to 0.
- Lamp test (SEG_LAMP_TEST_EN defined): lamp_test = 1 with brightness = 1 -> seg_out = 8'hFF for 7 subticks per slot, and the guard is still blank.
